ntt_ctrl: RTL and testbench
===========================

# ntt_ctrl

Sequencer for the 256-point forward NTT (Kyber schedule, 7 layers, len = 128 down to 2) driving two parallel butterfly units and the dual-port twiddle ROM. Each issue cycle emits one coefficient-address pair per butterfly unit, one twiddle ROM address per ROM port, and a delayed write-back address stream matched to butterfly latency. Layers are separated by a pipeline drain, so each layer reads only fully written-back data.

## Interface
- BFU_LAT, 3: cycles from twiddle data valid (ROM output) to butterfly result valid; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- hold  in  1  suppress issue this cycle (ISSUE state only).
- busy  out  1  high from first issue cycle through last write-back cycle.
- done  out  1  one-cycle pulse after last write-back.
- layer  out  3  current layer 0..6.
- rd_valid  out  1  read addresses valid this cycle.
- rd_a0, rd_b0, rd_a1, rd_b1  out  8 each  coefficient indices j and j+len for BFU0/BFU1.
- tw_addr1, tw_addr2  out  8 each  twiddle ROM addresses for BFU0/BFU1; ROM data valid next cycle.
- wr_valid  out  1  write-back valid.
- wr_a0, wr_b0, wr_a1, wr_b1  out  8 each  write-back indices; rd_* delayed exactly BFU_LAT+1 cycles.

## Operation
- FSM: IDLE -> ISSUE on start; ISSUE -> DRAIN after issue count 63 of the current layer; DRAIN -> ISSUE (layer+1) after BFU_LAT+1 drain cycles when layer<6; DRAIN -> DONE when layer==6; DONE -> IDLE unconditionally (1 cycle).
- Per layer: len = 128 >> layer; issue counter cnt 0..63. BFU0 butterfly index b0 = cnt, BFU1 b1 = cnt+64.
- For butterfly index b: group = b >> (7-layer), off = b & (len-1), j = group*2*len + off; outputs j and j+len; twiddle address k = (128 >> (7-layer))... equivalently k = (1<<layer) + group, range 1..127 (ROM entry 0 never addressed).
- All arithmetic unsigned 8-bit; no wrap occurs (max index 255).
- hold=1 in ISSUE: cnt frozen, rd_valid=0, rd_*/tw_* hold previous values; in-flight pipeline keeps shifting. hold ignored in IDLE/DRAIN/DONE.
- start while busy or in DONE: ignored. start and hold both high in IDLE: start accepted.
- Write-back pipeline: BFU_LAT+1 stage shift register of {rd_valid, rd_a0..rd_b1}; shifts every cycle regardless of hold.
- Reset (any time, including mid-transform): state IDLE, layer 0, cnt 0, all outputs 0, write-back pipeline cleared (no stale wr_valid after release).

## Timing
- All outputs registered; reset value 0 for every output.
- start high in cycle 0 -> rd_valid high cycles 1..64 (layer 0, no hold); tw data at ROM output cycles 2..65.
- wr_valid for issue at cycle t appears at t+BFU_LAT+1.
- Next layer first issue = last issue + BFU_LAT + 2 (write of last result lands before first read).
- BFU_LAT=3, no hold: layer L issues cycles 1+68L..64+68L; last wr_valid cycle 476; busy high cycles 1..476; done high cycle 477 only; start re-accepted from cycle 478.
- Each hold cycle in ISSUE extends all subsequent timing by exactly one cycle.

## Test plan
- Reset, then start=1 one cycle, BFU_LAT=3 -> first rd_valid cycle 1 with a0=0,b0=128,a1=64,b1=192,tw1=tw2=1; 448 rd_valid cycles total; done only at cycle 477.
- Layer 1 first issue (cycle 69) -> a0=0,b0=64,tw1=2; a1=128,b1=192,tw2=3.
- Layer 6 first/last issue -> cnt0: a0=0,b0=2,tw1=64,a1=128,b1=130,tw2=96; cnt63: a0=125,b0=127,tw1=95,a1=253,b1=255,tw2=127; every index 0..255 touched exactly once per layer.
- Scoreboard: each wr_* tuple equals rd_* tuple from BFU_LAT+1 cycles earlier; no rd_valid in cycles where any prior-layer wr_valid is still pending.
- hold high 5 random cycles in layer 3 -> rd_valid low those cycles, address sequence unchanged, done delayed exactly 5 cycles; start pulsed mid-run -> ignored.
- rst_n low at cycle 200 for 2 cycles -> all outputs 0 immediately, no wr_valid after release; new start -> full correct transform from layer 0.

Source files
------------

// File: rtl/ntt_ctrl.sv
// Issue/drain sequencer for the 256-point Kyber forward NTT: two butterflies per issue
// cycle, one twiddle address per ROM port, write-back addresses delayed by BFU_LAT+1.

module ntt_ctrl #(
    parameter int unsigned BFU_LAT = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       hold_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] layer_o,
    output logic       rd_valid_o,
    output logic [7:0] rd_a0_o,
    output logic [7:0] rd_b0_o,
    output logic [7:0] rd_a1_o,
    output logic [7:0] rd_b1_o,
    output logic [7:0] tw_addr1_o,
    output logic [7:0] tw_addr2_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_a0_o,
    output logic [7:0] wr_b0_o,
    output logic [7:0] wr_a1_o,
    output logic [7:0] wr_b1_o
);

    localparam int unsigned Stages    = BFU_LAT + 1;
    localparam logic [3:0]  DrainLast = 4'(BFU_LAT);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [7:0] a1;
        logic [7:0] b1;
    } rd_t;

    function automatic logic [7:0] group_of(input logic [7:0] b, input logic [2:0] l);
        return b >> (3'd7 - l);
    endfunction

    // j = group * 2 * len + (b mod len), with 2 * len == 1 << (8 - layer)
    function automatic logic [7:0] j_of(input logic [7:0] b, input logic [2:0] l);
        logic [7:0] len;
        len = 8'd128 >> l;
        return (group_of(b, l) << (4'd8 - {1'b0, l})) | (b & (len - 8'd1));
    endfunction

    function automatic logic [7:0] tw_of(input logic [7:0] b, input logic [2:0] l);
        return (8'd1 << l) + group_of(b, l);
    endfunction

    state_e     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [5:0] cnt_q, cnt_d;
    logic [3:0] drain_q, drain_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    rd_t        rd_q, rd_d;
    logic [7:0] tw1_q, tw1_d;
    logic [7:0] tw2_q, tw2_d;
    rd_t        pipe_q [Stages];

    logic       emit;
    logic [7:0] bidx0, bidx1, j0, j1, len_cur;

    assign bidx0   = {2'b00, cnt_q};
    assign bidx1   = {2'b01, cnt_q};
    assign j0      = j_of(bidx0, layer_q);
    assign j1      = j_of(bidx1, layer_q);
    assign len_cur = 8'd128 >> layer_q;

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        rd_d      = rd_q;
        rd_d.valid = 1'b0;
        tw1_d     = tw1_q;
        tw2_d     = tw2_q;
        emit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done_q still high means the DONE pulse is on the outputs; start not yet legal
                if (start_i && !done_q) begin
                    emit    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!hold_i) begin
                    emit = 1'b1;
                    if (cnt_q == 6'd63) begin
                        state_d = StDrain;
                        drain_d = 4'd0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    if (layer_q == 3'd6) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        layer_d = layer_q + 3'd1;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
                layer_d = 3'd0;
            end
            default: state_d = StIdle;
        endcase

        if (emit) begin
            cnt_d      = cnt_q + 6'd1;
            rd_d.valid = 1'b1;
            rd_d.a0    = j0;
            rd_d.b0    = j0 + len_cur;
            rd_d.a1    = j1;
            rd_d.b1    = j1 + len_cur;
            tw1_d      = tw_of(bidx0, layer_q);
            tw2_d      = tw_of(bidx1, layer_q);
        end

        busy_d = emit || (state_q == StIssue) || (state_q == StDrain);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            layer_q <= 3'd0;
            cnt_q   <= 6'd0;
            drain_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            tw1_q   <= 8'd0;
            tw2_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            tw1_q   <= tw1_d;
            tw2_q   <= tw2_d;
        end
    end

    // Write-back delay line shifts every cycle, independent of hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Stages); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_q;
            for (int i = 1; i < int'(Stages); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign layer_o    = layer_q;
    assign rd_valid_o = rd_q.valid;
    assign rd_a0_o    = rd_q.a0;
    assign rd_b0_o    = rd_q.b0;
    assign rd_a1_o    = rd_q.a1;
    assign rd_b1_o    = rd_q.b1;
    assign tw_addr1_o = tw1_q;
    assign tw_addr2_o = tw2_q;
    assign wr_valid_o = pipe_q[Stages-1].valid;
    assign wr_a0_o    = pipe_q[Stages-1].a0;
    assign wr_b0_o    = pipe_q[Stages-1].b0;
    assign wr_a1_o    = pipe_q[Stages-1].a1;
    assign wr_b1_o    = pipe_q[Stages-1].b1;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: fixed-cycle checks plus a per-cycle address model
// and write-back delay scoreboard.

module tb_ntt_ctrl;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, hold;
    logic       busy, done, rd_valid, wr_valid;
    logic [2:0] layer;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1, tw1, tw2, wr_a0, wr_b0, wr_a1, wr_b1;

    always #5 clk = ~clk;

    ntt_ctrl #(.BFU_LAT(LAT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .hold_i     (hold),
        .busy_o     (busy),
        .done_o     (done),
        .layer_o    (layer),
        .rd_valid_o (rd_valid),
        .rd_a0_o    (rd_a0),
        .rd_b0_o    (rd_b0),
        .rd_a1_o    (rd_a1),
        .rd_b1_o    (rd_b1),
        .tw_addr1_o (tw1),
        .tw_addr2_o (tw2),
        .wr_valid_o (wr_valid),
        .wr_a0_o    (wr_a0),
        .wr_b0_o    (wr_b0),
        .wr_a1_o    (wr_a1),
        .wr_b1_o    (wr_b1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          abs_cyc = 100;
    logic [32:0] hist [16];
    int          mlayer, mcnt;
    int          tcount [256];
    int          n_rd, n_wr, n_done, done_at, busy_first, busy_last, wr_last;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ej(input int b, input int l);
        int len;
        len = 128 >> l;
        return 8'((b / len) * 2 * len + (b % len));
    endfunction

    function automatic logic [7:0] etw(input int b, input int l);
        return 8'((1 << l) + b / (128 >> l));
    endfunction

    function automatic logic [127:0] outs_now();
        return {busy, done, layer, rd_valid, rd_a0, rd_b0, rd_a1, rd_b1, tw1, tw2,
                wr_valid, wr_a0, wr_b0, wr_a1, wr_b1};
    endfunction

    task automatic model_reset();
        mlayer = 0;
        mcnt   = 0;
        for (int i = 0; i < 256; i++) tcount[i] = 0;
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_done = 0; done_at = -1;
        busy_first = -1; busy_last = -1; wr_last = -1;
    endtask

    task automatic check_cycle();
        logic [32:0] cur;
        int          b0, b1, len, bad;
        cur = {rd_valid, rd_a0, rd_b0, rd_a1, rd_b1};
        chk("wb_delay", {wr_valid, wr_a0, wr_b0, wr_a1, wr_b1}, hist[(abs_cyc - LAT - 1) & 15]);
        hist[abs_cyc & 15] = cur;
        if (rd_valid) begin
            b0  = mcnt;
            b1  = mcnt + 64;
            len = 128 >> mlayer;
            chk("rd_addr", {rd_a0, rd_b0, tw1, rd_a1, rd_b1, tw2},
                {ej(b0, mlayer), 8'(ej(b0, mlayer) + len), etw(b0, mlayer),
                 ej(b1, mlayer), 8'(ej(b1, mlayer) + len), etw(b1, mlayer)});
            chk("rd_layer", layer, mlayer);
            tcount[rd_a0]++; tcount[rd_b0]++; tcount[rd_a1]++; tcount[rd_b1]++;
            n_rd++;
            mcnt++;
            if (mcnt == 64) begin
                bad = 0;
                for (int i = 0; i < 256; i++) if (tcount[i] != 1) bad++;
                chk("touch_once", bad, 0);
                for (int i = 0; i < 256; i++) tcount[i] = 0;
                mcnt = 0;
                mlayer++;
            end
        end
        if (wr_valid) begin n_wr++; wr_last = cyc; end
        if (done) begin n_done++; done_at = cyc; end
        if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        abs_cyc++;
        check_cycle();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic begin_run();
        clear_stats();
        model_reset();
        cyc   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int exp_done);
        chk({tag, "_rd_count"}, n_rd, 448);
        chk({tag, "_wr_count"}, n_wr, 448);
        chk({tag, "_done_count"}, n_done, 1);
        chk({tag, "_done_at"}, done_at, exp_done);
        chk({tag, "_busy_first"}, busy_first, 1);
        chk({tag, "_busy_last"}, busy_last, exp_done - 1);
        chk({tag, "_wr_last"}, wr_last, exp_done - 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        for (int i = 0; i < 16; i++) hist[i] = '0;
        model_reset();
        clear_stats();
        repeat (3) tick();
        chk("reset_outs", outs_now(), 128'd0);
        rst_n = 1'b1;
        tick();

        // Run 1: clean transform
        begin_run();
        chk("first_issue", {busy, rd_valid, rd_a0, rd_b0, rd_a1, rd_b1, tw1, tw2},
            {1'b1, 1'b1, 8'd0, 8'd128, 8'd64, 8'd192, 8'd1, 8'd1});
        run_to(68);
        chk("drain_gap", {rd_valid, wr_valid}, 2'b01);
        run_to(69);
        chk("layer1_first", {rd_valid, rd_a0, rd_b0, tw1, rd_a1, rd_b1, tw2},
            {1'b1, 8'd0, 8'd64, 8'd2, 8'd128, 8'd192, 8'd3});
        run_to(409);
        chk("layer6_first", {rd_valid, layer, rd_a0, rd_b0, tw1, rd_a1, rd_b1, tw2},
            {1'b1, 3'd6, 8'd0, 8'd2, 8'd64, 8'd128, 8'd130, 8'd96});
        run_to(472);
        chk("layer6_last", {rd_valid, rd_a0, rd_b0, tw1, rd_a1, rd_b1, tw2},
            {1'b1, 8'd125, 8'd127, 8'd95, 8'd253, 8'd255, 8'd127});
        run_to(476);
        chk("last_wb", {done, wr_valid, busy}, 3'b011);
        run_to(477);
        chk("done_pulse", {done, busy, wr_valid}, 3'b100);
        start = 1'b1;  // while DONE is showing: must be ignored
        tick();
        start = 1'b0;
        chk("start_in_done", {rd_valid, busy, done}, 3'b000);
        run_to(480);
        check_run("run1", 477);

        // Run 2: five hold cycles in layer 3, start pulsed mid-run
        begin_run();
        run_to(210);
        chk("pre_hold", {rd_valid, rd_a0}, {1'b1, 8'd5});
        hold = 1'b1;
        tick();
        chk("hold_a", {rd_valid, layer, rd_a0}, {1'b0, 3'd3, 8'd5});
        tick();
        hold = 1'b0;
        chk("hold_b", {rd_valid, rd_a0}, {1'b0, 8'd5});
        tick();
        chk("post_hold", {rd_valid, rd_a0}, {1'b1, 8'd6});
        run_to(230); hold = 1'b1; tick(); hold = 1'b0;
        chk("hold_c", rd_valid, 1'b0);
        run_to(250); hold = 1'b1; tick(); hold = 1'b0;
        chk("hold_d", rd_valid, 1'b0);
        run_to(260); hold = 1'b1; tick(); hold = 1'b0;
        chk("hold_e", rd_valid, 1'b0);
        run_to(300); start = 1'b1; tick(); start = 1'b0;
        run_to(481);
        chk("hold_done_late", {done, wr_valid, busy}, 3'b011);
        run_to(485);
        check_run("run2", 482);

        // Run 3: reset mid-transform, then a full transform
        begin_run();
        run_to(200);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs_now(), 128'd0);
        for (int i = 0; i < 16; i++) hist[i] = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        clear_stats();
        repeat (10) tick();
        chk("no_stale_wr", n_wr, 0);
        chk("no_spurious_rd", n_rd, 0);
        begin_run();
        chk("rerun_first_issue", {rd_valid, layer, rd_a0, rd_b0, rd_a1, rd_b1, tw1, tw2},
            {1'b1, 3'd0, 8'd0, 8'd128, 8'd64, 8'd192, 8'd1, 8'd1});
        run_to(480);
        check_run("run3", 477);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
